// File: rtl/ex_alu_unit.sv
// EX-stage execute unit: single-cycle ALU ops plus iterative unsigned multu/divu
// into HI/LO, with a ready/valid handshake so the pipeline can stall while busy.
module ex_alu_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic [3:0]         alu_ctrl,
  output logic               illegal,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_MULU = 4'b1010;
  localparam logic [3:0] C_DIVU = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_MFHI = 4'b1101;
  localparam logic [3:0] C_MFLO = 4'b1110;
  localparam logic [3:0] C_ILL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 illegal_q, illegal_d;
  logic                 zero_q, zero_d;
  logic [3:0]           alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [3:0]           ctrl_s;
  logic                 illegal_s;
  logic [WIDTH-1:0]     alu_s;
  logic                 accept_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;

  assign accept_s = in_valid & in_ready_q;

  // Multiply: acc holds {partial sum, remaining multiplier bits}; add then shift right.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

  // Restoring divide: acc holds {remainder, dividend bits shifting into quotient}.
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opb_q};
  assign div_next_s  = (div_shift_s >= {1'b0, opb_q}) ?
                       {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1} :
                       {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  always_comb begin
    ctrl_s    = C_AND;
    illegal_s = 1'b0;
    case (alu_op)
      2'b00: ctrl_s = C_ADD;
      2'b01: ctrl_s = C_SUB;
      2'b11: ctrl_s = C_AND;
      default: begin
        case (funct)
          6'b100000: ctrl_s = C_ADD;
          6'b100010: ctrl_s = C_SUB;
          6'b100100: ctrl_s = C_AND;
          6'b100101: ctrl_s = C_OR;
          6'b100111: ctrl_s = C_NOR;
          6'b101010: ctrl_s = C_SLT;
          6'b000000: ctrl_s = C_SLL;
          6'b000010: ctrl_s = C_SRL;
          6'b011001: ctrl_s = C_MULU;
          6'b011011: ctrl_s = C_DIVU;
          6'b010000: ctrl_s = C_MFHI;
          6'b010010: ctrl_s = C_MFLO;
          default: begin
            ctrl_s    = C_ILL;
            illegal_s = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (ctrl_s)
      C_ADD:  alu_s = src_a + src_b;
      C_SUB:  alu_s = src_a - src_b;
      C_AND:  alu_s = src_a & src_b;
      C_OR:   alu_s = src_a | src_b;
      C_NOR:  alu_s = ~(src_a | src_b);
      C_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      C_SLL:  alu_s = src_b << shamt;
      C_SRL:  alu_s = src_b >> shamt;
      C_MFHI: alu_s = hi_q;
      C_MFLO: alu_s = lo_q;
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    zero_d      = zero_q;
    alu_ctrl_d  = alu_ctrl_q;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          alu_ctrl_d = ctrl_s;
          if (illegal_s) begin
            result_d    = {WIDTH{1'b0}};
            zero_d      = 1'b1;
            out_valid_d = 1'b1;
            illegal_d   = 1'b1;
          end else if ((ctrl_s == C_MULU) || (ctrl_s == C_DIVU)) begin
            state_d    = (ctrl_s == C_MULU) ? S_MUL : S_DIV;
            in_ready_d = 1'b0;
            cnt_d      = CNT_W'(WIDTH);
            opb_d      = (ctrl_s == C_MULU) ? src_a : src_b;
            acc_d      = {{WIDTH{1'b0}}, ((ctrl_s == C_MULU) ? src_b : src_a)};
          end else begin
            result_d    = alu_s;
            zero_d      = (alu_s == {WIDTH{1'b0}});
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next_s : div_next_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          hi_d        = acc_d[2*WIDTH-1:WIDTH];
          lo_d        = acc_d[WIDTH-1:0];
          result_d    = acc_d[WIDTH-1:0];
          zero_d      = (acc_d[WIDTH-1:0] == {WIDTH{1'b0}});
          out_valid_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      zero_q      <= 1'b1;
      alu_ctrl_q  <= 4'b0000;
      result_q    <= {WIDTH{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      zero_q      <= zero_d;
      alu_ctrl_q  <= alu_ctrl_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;
  assign zero      = zero_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Bench for ex_alu_unit: directed scenarios plus random traffic, checked every
// cycle against an arithmetic reference model of the operation semantics.
module tb_ex_alu_unit;
  localparam int W = 32;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_NOR = 4, K_SLT = 5, K_SLL = 6,
                 K_SRL = 7, K_MUL = 8, K_DIV = 9, K_MFHI = 10, K_MFLO = 11, K_ILL = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [W-1:0] src_a, src_b;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic [3:0]   alu_ctrl;
  logic         illegal;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic         m_ready, e_valid, e_ill, e_zero, ctrl_known;
  logic [W-1:0] e_res, m_hi, m_lo, p_hi, p_lo;
  logic [3:0]   e_ctrl;
  int           m_left;

  always #5 clk = ~clk;

  ex_alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .result(result), .zero(zero), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output int kind, output logic [3:0] ctrl);
    kind = K_ILL; ctrl = 4'b0000;
    if (op == 2'b00) begin kind = K_ADD; ctrl = 4'b0010; end
    else if (op == 2'b01) begin kind = K_SUB; ctrl = 4'b0110; end
    else if (op == 2'b11) begin kind = K_AND; ctrl = 4'b0000; end
    else if (f == 6'b100000) begin kind = K_ADD;  ctrl = 4'b0010; end
    else if (f == 6'b100010) begin kind = K_SUB;  ctrl = 4'b0110; end
    else if (f == 6'b100100) begin kind = K_AND;  ctrl = 4'b0000; end
    else if (f == 6'b100101) begin kind = K_OR;   ctrl = 4'b0001; end
    else if (f == 6'b100111) begin kind = K_NOR;  ctrl = 4'b1100; end
    else if (f == 6'b101010) begin kind = K_SLT;  ctrl = 4'b0111; end
    else if (f == 6'b000000) begin kind = K_SLL;  ctrl = 4'b1000; end
    else if (f == 6'b000010) begin kind = K_SRL;  ctrl = 4'b1001; end
    else if (f == 6'b011001) begin kind = K_MUL;  ctrl = 4'b1010; end
    else if (f == 6'b011011) begin kind = K_DIV;  ctrl = 4'b1011; end
    else if (f == 6'b010000) begin kind = K_MFHI; ctrl = 4'b1101; end
    else if (f == 6'b010010) begin kind = K_MFLO; ctrl = 4'b1110; end
  endfunction

  task automatic model_reset();
    m_ready = 1'b1; e_valid = 1'b0; e_ill = 1'b0; e_zero = 1'b1; e_res = '0;
    e_ctrl = 4'b0000; ctrl_known = 1'b1; m_hi = '0; m_lo = '0; m_left = 0;
  endtask

  // Advance the model by one rising edge, using the inputs presented before it.
  task automatic model_edge();
    int kind;
    logic [3:0] ctrl;
    logic [63:0] prod;
    longint sa, sb;
    e_valid = 1'b0; e_ill = 1'b0;
    if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; e_res = p_lo; e_zero = (p_lo == 0);
        e_valid = 1'b1; m_ready = 1'b1;
      end
    end else if (in_valid) begin
      ref_decode(alu_op, funct, kind, ctrl);
      e_ctrl = ctrl; ctrl_known = (kind != K_ILL);
      sa = longint'($signed(src_a)); sb = longint'($signed(src_b));
      if (kind == K_ILL) begin
        e_res = '0; e_zero = 1'b1; e_valid = 1'b1; e_ill = 1'b1;
      end else if (kind == K_MUL || kind == K_DIV) begin
        if (kind == K_MUL) begin
          prod = {32'd0, src_a} * {32'd0, src_b};
          p_hi = prod[63:32]; p_lo = prod[31:0];
        end else if (src_b == 0) begin
          p_hi = src_a; p_lo = 32'hFFFF_FFFF;
        end else begin
          p_hi = src_a % src_b; p_lo = src_a / src_b;
        end
        m_left = W; m_ready = 1'b0;
      end else begin
        case (kind)
          K_ADD:  e_res = src_a + src_b;
          K_SUB:  e_res = src_a - src_b;
          K_AND:  e_res = src_a & src_b;
          K_OR:   e_res = src_a | src_b;
          K_NOR:  e_res = ~(src_a | src_b);
          K_SLT:  e_res = (sa < sb) ? 32'd1 : 32'd0;
          K_SLL:  e_res = src_b << shamt;
          K_SRL:  e_res = src_b >> shamt;
          K_MFHI: e_res = m_hi;
          default: e_res = m_lo;
        endcase
        e_zero = (e_res == 0); e_valid = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("in_ready",  64'(in_ready),  64'(m_ready));
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("illegal",   64'(illegal),   64'(e_ill));
    chk("result",    64'(result),    64'(e_res));
    chk("zero",      64'(zero),      64'(e_zero));
    chk("hi",        64'(hi),        64'(m_hi));
    chk("lo",        64'(lo),        64'(m_lo));
    if (ctrl_known) chk("alu_ctrl", 64'(alu_ctrl), 64'(e_ctrl));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op = op; funct = f; shamt = sh; src_a = a; src_b = b; in_valid = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    set_in(op, f, sh, a, b);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic async_reset();
    reset = 1'b1; in_valid = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  logic [5:0] functs [12];

  initial begin
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h19, 6'h1b, 6'h10, 6'h12};
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'h00; shamt = 5'd0;
    src_a = '0; src_b = '0;
    model_reset();
    #2;
    compare();
    @(negedge clk);
    reset = 1'b0;

    issue(2'b10, 6'b100010, 5'd0, 32'd5, 32'd7);
    chk("t1 result", 64'(result), 64'h0000_0000_FFFF_FFFE);
    chk("t1 ctrl", 64'(alu_ctrl), 64'h6);
    chk("t1 valid", 64'(out_valid), 64'h1);
    cycle();
    chk("t1 valid pulse", 64'(out_valid), 64'h0);

    issue(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
    chk("t2 slt", 64'(result), 64'h1);
    issue(2'b01, 6'b111111, 5'd0, 32'h1234, 32'h1234);
    chk("t2 beq zero", 64'({zero, result}), 64'h1_0000_0000);

    issue(2'b10, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'd2);
    repeat (31) cycle();
    chk("t3 busy", 64'({in_ready, out_valid}), 64'h0);
    cycle();
    chk("t3 mul hi", 64'(hi), 64'h1);
    chk("t3 mul lo", 64'({out_valid, in_ready, result}), 64'h3_FFFF_FFFE);
    issue(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
    chk("t3 mfhi", 64'(result), 64'h1);

    issue(2'b10, 6'b011011, 5'd0, 32'd100, 32'd7);
    repeat (32) cycle();
    chk("t4 div", 64'({hi, lo}), {32'd2, 32'd14});
    set_in(2'b10, 6'b011011, 5'd0, 32'd9, 32'd0);
    repeat (33) cycle();
    in_valid = 1'b0;
    chk("t4 div0", 64'({hi, lo}), {32'd9, 32'hFFFF_FFFF});
    cycle();
    chk("t4 one accept", 64'(in_ready), 64'h1);

    issue(2'b10, 6'b111111, 5'd0, 32'd1, 32'd2);
    chk("t5 illegal", 64'({illegal, out_valid, result}), 64'h3_0000_0000);
    chk("t5 hilo kept", 64'({hi, lo}), {32'd9, 32'hFFFF_FFFF});
    issue(2'b10, 6'b011001, 5'd0, 32'd3, 32'd4);
    set_in(2'b00, 6'h00, 5'd0, 32'd1, 32'd2);
    repeat (32) cycle();
    chk("t5 mul done", 64'({out_valid, result}), 64'h1_0000_000C);
    cycle();
    in_valid = 1'b0;
    chk("t5 add next", 64'({out_valid, result}), 64'h1_0000_0003);

    issue(2'b10, 6'b011001, 5'd0, 32'd77, 32'd55);
    repeat (9) cycle();
    async_reset();
    chk("t6 reset", 64'({in_ready, out_valid, hi}), 64'h2_0000_0000);
    chk("t6 reset lo", 64'(lo), 64'h0);
    issue(2'b10, 6'b000000, 5'd4, 32'hDEAD, 32'd1);
    chk("t6 sll", 64'(result), 64'h10);

    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a, b;
      int sel;
      a = (i % 3 == 0) ? W'($urandom_range(0, 300)) : $urandom;
      sel = $urandom_range(0, 5);
      b = (sel == 0) ? '0 : (sel < 3) ? W'($urandom_range(1, 20)) : $urandom;
      set_in(2'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0) ? 6'($urandom) : functs[$urandom_range(0, 11)],
             5'($urandom), a, b);
      in_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    repeat (40) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
Parametrised EX-stage execute unit for the pipelined processor. It decodes ALUOp and funct internally and produces registered results. Single-cycle ops (add/sub/and/or/nor/slt/sll/srl) complete in 1 cycle. It adds iterative unsigned multiply/divide with HI/LO registers and a ready/valid handshake, so the hazard unit can stall IF/ID/EX while an op is busy.

Parameters:
WIDTH, 32, datapath width in bits; power of two, ≥8.
SHAMT_W, $clog2(WIDTH), shift-amount width.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operation presented this cycle.
in_ready  output  1  unit can accept; accept = in_valid & in_ready.
alu_op  input  2  00 add (lw/sw), 01 sub (beq), 10 R-type via funct, 11 and (andi).
funct  input  6  R-type function field.
shamt  input  SHAMT_W  shift amount for sll/srl.
src_a  input  WIDTH  operand A (rs).
src_b  input  WIDTH  operand B (rt/imm).
out_valid  output  1  one-cycle pulse: result/zero valid.
result  output  WIDTH  registered result.
zero  output  1  (result == 0), registered with result.
alu_ctrl  output  4  registered decoded control of last accepted op, for debug/trace.
illegal  output  1  one-cycle pulse with out_valid for unsupported funct.
hi, lo  output  WIDTH  HI/LO architectural registers.

Behaviour:
- Reset (async, immediate): FSM=IDLE; in_ready=1; out_valid=0; illegal=0; result=0; zero=1; alu_ctrl=0; hi=0; lo=0; counter=0.
- Decode: ALUOp 00→add 0010; 01→sub 0110; 11→and 0000.
- Decode, ALUOp 10 by funct:
  - 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 100111 nor 1100; 101010 slt 0111 (signed); 000000 sll 1000; 000010 srl 1001.
  - 011001 multu 1010; 011011 divu 1011; 010000 mfhi 1101; 010010 mflo 1110.
  - Other funct → illegal.
- Arithmetic: add/sub wrap mod 2^WIDTH, no overflow trap. slt result is 0 or 1, zero-extended. Shifts are logical and use shamt only.
- FSM states: IDLE, MUL, DIV. in_ready=1 only in IDLE.
- Single-cycle op accepted at edge k:
  - result, zero, alu_ctrl and out_valid registered at edge k; out_valid high for exactly one cycle; state stays IDLE.
  - mfhi/mflo return hi/lo as held before edge k.
- Illegal: accepted at edge k → result=0, zero=1, out_valid=1, illegal=1 for one cycle. HI/LO unchanged.
- multu accepted at edge k:
  - IDLE→MUL; counter=WIDTH; operands latched; in_ready=0 from edge k.
  - Shift-add, one bit per edge.
  - At edge k+WIDTH: {hi,lo}=src_a*src_b (2·WIDTH unsigned); result=lo; zero=(lo==0); out_valid=1; state→IDLE.
  - in_ready=1 in that same cycle.
- divu: same timing via restoring division; lo=quotient, hi=remainder.
  - Divisor 0: still WIDTH cycles; lo=all ones, hi=src_a.
- Back-to-back: a new op may be accepted in the cycle out_valid is high. A single-cycle op accepted every cycle gives out_valid high every cycle.
- in_valid while in_ready=0 is ignored; the stage stalls.
- Operands are latched at accept; later input changes have no effect.
- HI/LO change only at mul/div completion. Internal partial products are never visible on hi/lo.
- Reset mid-MUL/DIV: abort immediately; no out_valid; hi/lo=0.
- Outputs hold their last values between out_valid pulses.

Test Plan:
1. WIDTH=32, ALUOp=10, funct=100010, a=5, b=7 → next cycle result=0xFFFFFFFE, zero=0, alu_ctrl=0110, out_valid one cycle.
2. ALUOp=10, slt, a=0xFFFFFFFF, b=1 → result=1. ALUOp=01, a=b=0x1234 → result=0, zero=1.
3. multu a=0xFFFFFFFF, b=2 at edge k:
   - in_ready=0 for 32 cycles; out_valid at edge k+32; hi=1, lo=0xFFFFFFFE, result=0xFFFFFFFE.
   - Follow with mfhi → result=1.
4. divu a=100, b=7 → lo=14, hi=2 after 32 cycles. divu a=9, b=0 → lo=0xFFFFFFFF, hi=9. Holding in_valid during busy → exactly one accept.
5. ALUOp=10, funct=111111 → illegal=1, result=0, hi/lo unchanged. Also: issue add in the completion cycle of multu → both results in consecutive cycles.
6. Assert reset at cycle 10 of a multu → in_ready=1, hi=lo=0, no out_valid. Then sll shamt=4, b=0x1 → result=0x10.
